diff_freq_serial_in: RTL and testbench
======================================

Name: diff_freq_serial_in

Overview:
- Receive-side counterpart of the variable-frequency serial output path.
- Samples a single-wire serial input whose per-bit period is set by a frequency pattern: bit i lasts FAST_PERIOD cycles if pattern[i]=1, otherwise SLOW_PERIOD cycles.
- Packs DATA_BIT samples into a word.
- Returns the word to the host byte by byte through the UART transmitter handshake.

Parameters:
- DATA_BIT, 32, bits captured per run; multiple of 8.
- FAST_PERIOD, 4, clock cycles per bit when pattern bit=1; >=4.
- SLOW_PERIOD, 8, clock cycles per bit when pattern bit=0; >=4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_serial_in  in  1  asynchronous serial input; idle low.
- i_start  in  1  one-cycle start tick; honoured only in S_IDLE.
- i_stop  in  1  abort tick; honoured only in S_SAMPLE.
- i_freq_pattern  in  DATA_BIT  per-bit frequency select; latched on accepted i_start.
- i_tx_done_tick  in  1  UART transmitter finished current byte.
- o_tx_data  out  8  byte presented to UART transmitter.
- o_tx_start  out  1  one-cycle request to UART transmitter.
- o_capture  out  DATA_BIT  last fully captured word.
- o_busy  out  1  high in any state other than S_IDLE.
- o_bit_tick  out  1  pulse on last cycle of each sampled bit.
- o_done_tick  out  1  pulse after last byte acknowledged.

Behaviour:
- Reset: state S_IDLE; all outputs 0; o_capture=0; synchronizer flops=0; counters=0.
- i_serial_in passes through a 2-flop synchronizer. The sampled value at bit-counter c therefore reflects the pin at c-2.
- S_IDLE:
  - On i_start: latch i_freq_pattern, clear shift register, bit_idx=0, cnt=0, go to S_SAMPLE.
  - A start tick at cycle T makes T+1 the first cycle of bit 0.
- S_SAMPLE:
  - P = FAST_PERIOD if pattern[bit_idx]=1, else SLOW_PERIOD.
  - cnt runs 0..P-1.
  - At cnt==P/2 (integer division), capture the synchronized input into shift[bit_idx]. LSB is received first.
  - At cnt==P-1: o_bit_tick=1, cnt=0, bit_idx++.
  - If bit_idx==DATA_BIT-1 at cnt==P-1: o_capture<=assembled word (including this bit), byte_idx=0, go to S_SEND.
  - i_stop: go to S_IDLE next cycle; o_capture unchanged; no bytes sent; no done tick.
  - i_start is ignored here.
- S_SEND:
  - o_tx_start=1 for exactly this one cycle.
  - o_tx_data = o_capture[8*byte_idx+7 : 8*byte_idx]. Least-significant byte goes first.
  - Next state S_WAIT.
- S_WAIT:
  - o_tx_data held stable.
  - On i_tx_done_tick: if byte_idx==DATA_BIT/8-1 go to S_DONE, else byte_idx++ and go to S_SEND.
  - i_stop and i_start are ignored; an in-flight UART frame is never aborted.
- S_DONE: o_done_tick=1 for one cycle, then S_IDLE.
- o_tx_data keeps its last value in S_IDLE. o_tx_start and o_done_tick are only asserted as stated above.
- i_tx_done_tick outside S_WAIT is ignored.
- Simultaneous i_stop and final cnt==P-1 of the last bit: stop wins; no capture update.
- Reset mid-operation, any state: immediate return to reset values. A partial UART frame is the transmitter's concern.
- Total sample duration = sum over i of P(i) cycles. No gap between bits.
- Bit-to-bit frequency changes take effect at the bit boundary with no extra cycles.

Test Plan:
- Pattern 0xFFFFFFFF, pin driven with 0xA5A51234 (LSB first, 4 cycles per bit, aligned to T+1-2):
  - 32 o_bit_ticks; last at T+128; o_capture=0xA5A51234.
  - Tx bytes 0x34, 0x12, 0xA5, 0xA5.
  - o_tx_start one cycle after each i_tx_done_tick.
  - o_done_tick one cycle after the 4th i_tx_done_tick.
- Pattern 0x0000FFFF, pin 0x0F0F00FF: bits 0-15 at 4 cycles, bits 16-31 at 8 cycles.
  - Last bit tick at T+192.
  - o_capture=0x0F0F00FF.
- i_stop at bit 10 of a run:
  - o_busy drops next cycle; o_capture keeps the previous value.
  - No o_tx_start; no o_done_tick.
  - A fresh i_start then captures correctly.
- i_start and i_stop during S_WAIT:
  - Both ignored; o_tx_data is stable.
  - Remaining bytes are sent once i_tx_done_tick arrives.
- rst_n low during S_WAIT after byte 1:
  - All outputs 0 at once; state S_IDLE.
  - No o_done_tick after rst_n is released.
- Spurious i_tx_done_tick in S_IDLE and S_SAMPLE: no effect on byte_idx, state, or o_tx_start.

Source files
------------

// File: rtl/diff_freq_serial_in.sv
// Samples a variable-rate serial word (per-bit period from a pattern) and returns it byte-wise via the UART tx handshake.
// Sampling is 2-cycle synchronized; each byte waits for i_tx_done_tick, so the UART alone paces the return path.
module diff_freq_serial_in #(
  parameter int DATA_BIT    = 32,
  parameter int FAST_PERIOD = 4,
  parameter int SLOW_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_serial_in,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic                i_tx_done_tick,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  output logic [DATA_BIT-1:0] o_capture,
  output logic                o_busy,
  output logic                o_bit_tick,
  output logic                o_done_tick
);

  localparam int NBYTE = DATA_BIT / 8;
  localparam int MAXP  = (FAST_PERIOD > SLOW_PERIOD) ? FAST_PERIOD : SLOW_PERIOD;
  localparam int CW    = $clog2(MAXP);
  localparam int BW    = $clog2(DATA_BIT);
  localparam int YW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;

  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_PERIOD - 1);
  localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_PERIOD - 1);
  localparam logic [CW-1:0] FAST_HALF = CW'(FAST_PERIOD / 2);
  localparam logic [CW-1:0] SLOW_HALF = CW'(SLOW_PERIOD / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                sync1, sync2;
  logic [DATA_BIT-1:0] pattern;
  logic [DATA_BIT-1:0] shift;
  logic [DATA_BIT-1:0] capture_q;
  logic [BW-1:0]       bit_idx;
  logic [CW-1:0]       cnt;
  logic [YW-1:0]       byte_idx;
  logic [7:0]          tx_hold;
  logic [7:0]          tx_byte;
  logic [CW-1:0]       cur_last;
  logic [CW-1:0]       cur_half;
  logic                bit_last;
  logic                last_byte;
  logic                capture_ld;

  // Period of the bit currently on the wire; switches exactly at the bit boundary.
  assign cur_last  = pattern[bit_idx] ? FAST_LAST : SLOW_LAST;
  assign cur_half  = pattern[bit_idx] ? FAST_HALF : SLOW_HALF;
  assign bit_last  = (cnt == cur_last);
  assign last_byte = (byte_idx == YW'(NBYTE - 1));
  assign tx_byte   = capture_q[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_serial_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture_ld = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        // Abort takes priority over completing the final bit.
        if (i_stop) begin
          state_nxt = S_IDLE;
        end else if (bit_last && bit_idx == BW'(DATA_BIT - 1)) begin
          capture_ld = 1'b1;
          state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done_tick) state_nxt = last_byte ? S_DONE : S_SEND;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      shift   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
    end else if (state == S_IDLE && i_start) begin
      pattern <= i_freq_pattern;
      shift   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
    end else if (state == S_SAMPLE && !i_stop) begin
      // Mid-bit sample lands before the last cycle, so shift is complete when the word is captured.
      if (cnt == cur_half) shift[bit_idx] <= sync2;
      if (bit_last) begin
        cnt     <= '0;
        bit_idx <= bit_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture_q <= '0;
      byte_idx  <= '0;
      tx_hold   <= '0;
    end else begin
      if (capture_ld) begin
        capture_q <= shift;
        byte_idx  <= '0;
      end else if (state == S_WAIT && i_tx_done_tick && !last_byte) begin
        byte_idx <= byte_idx + 1'b1;
      end
      if (state == S_SEND) tx_hold <= tx_byte;
    end
  end

  assign o_tx_data   = (state == S_SEND) ? tx_byte : tx_hold;
  assign o_tx_start  = (state == S_SEND);
  assign o_capture   = capture_q;
  assign o_busy      = (state != S_IDLE);
  assign o_bit_tick  = (state == S_SAMPLE) && bit_last;
  assign o_done_tick = (state == S_DONE);

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Randomized scoreboard bench for diff_freq_serial_in with a UART responder model.
module tb_diff_freq_serial_in;

  localparam int DB = 32;
  localparam int FP = 4;
  localparam int SP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_serial_in;
  logic          i_start;
  logic          i_stop;
  logic [DB-1:0] i_freq_pattern;
  logic          i_tx_done_tick;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic [DB-1:0] o_capture;
  logic          o_busy;
  logic          o_bit_tick;
  logic          o_done_tick;

  logic uart_done;
  logic spur_done;
  assign i_tx_done_tick = uart_done | spur_done;

  diff_freq_serial_in #(.DATA_BIT(DB), .FAST_PERIOD(FP), .SLOW_PERIOD(SP)) dut (
    .clk(clk), .rst_n(rst_n), .i_serial_in(i_serial_in), .i_start(i_start), .i_stop(i_stop),
    .i_freq_pattern(i_freq_pattern), .i_tx_done_tick(i_tx_done_tick), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_capture(o_capture), .o_busy(o_busy), .o_bit_tick(o_bit_tick),
    .o_done_tick(o_done_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_cap[$];
  int          exp_last[$];

  int         tick_cnt = 0;
  int         last_tick_cyc = 0;
  int         done_cnt = 0;
  int         bytes_in_run = 0;
  int         last_done_cyc = 0;
  logic       in_wait = 1'b0;
  logic [7:0] held = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a byte or a completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_wait = 1'b0;
    end else begin
      if (i_start && !o_busy) begin
        tick_cnt     = 0;
        bytes_in_run = 0;
      end
      if (o_bit_tick) begin
        tick_cnt++;
        last_tick_cyc = cyc;
      end
      if (in_wait && !o_tx_start) chk("tx_data_stable", {24'h0, o_tx_data}, {24'h0, held});
      if (o_tx_start) begin
        if (exp_bytes.size() == 0) begin
          flag_fail("unexpected_tx_start");
        end else begin
          chk("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_bytes.pop_front()});
          if (bytes_in_run == 0) chk("first_tx_start_cycle", cyc, last_tick_cyc + 1);
          else                   chk("tx_start_after_done", cyc, last_done_cyc + 1);
        end
        bytes_in_run++;
        in_wait = 1'b1;
        held    = o_tx_data;
      end
      if (i_tx_done_tick && in_wait) begin
        in_wait       = 1'b0;
        last_done_cyc = cyc;
      end
      if (o_done_tick) begin
        done_cnt++;
        if (exp_cap.size() == 0) begin
          flag_fail("unexpected_done_tick");
        end else begin
          chk("capture", o_capture, exp_cap.pop_front());
          chk("bit_tick_count", tick_cnt, DB);
          chk("last_bit_tick_cycle", last_tick_cyc, exp_last.pop_front());
          chk("done_tick_cycle", cyc, last_done_cyc + 1);
          chk("bytes_sent", bytes_in_run, DB / 8);
        end
      end
    end
  end

  // UART transmitter model: acknowledges each byte after a random delay, abandoning it on reset.
  initial begin
    int   d;
    logic ab;
    uart_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start && rst_n) begin
        d  = $urandom_range(3, 10);
        ab = 1'b0;
        repeat (d) begin
          @(posedge clk);
          if (!rst_n) ab = 1'b1;
        end
        if (!ab) begin
          #1 uart_done = 1'b1;
          @(posedge clk);
          #1 uart_done = 1'b0;
        end
      end
    end
  end

  // Drives one capture run; the pin carries bit i for P(i) cycles starting two cycles before bit i's window.
  task automatic run_capture(input logic [31:0] data, input logic [31:0] pat, input int stop_bit,
                             input int spur_j, input logic [31:0] prev_cap);
    logic pin_q[$];
    int   total;
    int   stop_j;
    int   t0;
    total  = 0;
    stop_j = -1;
    t0     = 0;
    for (int i = 0; i < DB; i++) begin
      int p;
      p = pat[i] ? FP : SP;
      if (i == stop_bit) stop_j = 2 + total + 1;
      for (int k = 0; k < p; k++) pin_q.push_back(data[i]);
      total += p;
    end
    i_freq_pattern = pat;
    for (int j = 0; j < total; j++) begin
      @(posedge clk); #1;
      i_serial_in = pin_q[j];
      i_start     = (j == 1);
      i_stop      = (j == stop_j);
      spur_done   = (j == 0) || (j == spur_j);
      if (j == 1) t0 = cyc;
      if (j == stop_j) begin
        @(posedge clk); #1;
        i_stop    = 1'b0;
        spur_done = 1'b0;
        chk("busy_after_stop", {31'h0, o_busy}, 32'h0);
        chk("capture_after_stop", o_capture, prev_cap);
        break;
      end
    end
    @(posedge clk); #1;
    i_start     = 1'b0;
    i_stop      = 1'b0;
    spur_done   = 1'b0;
    i_serial_in = 1'b0;
    if (stop_j < 0) begin
      exp_cap.push_back(data);
      exp_last.push_back(t0 + total);
      for (int b = 0; b < DB / 8; b++) exp_bytes.push_back(data[8*b +: 8]);
    end
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == base) flag_fail("wait_done_timeout");
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_tx_start(input int count);
    int seen;
    int n;
    seen = 0;
    n    = 0;
    while (seen < count && n < 2000) begin
      @(negedge clk);
      if (o_tx_start) seen++;
      n++;
    end
    if (seen < count) flag_fail("wait_tx_start_timeout");
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tx_data"},   {24'h0, o_tx_data},   32'h0);
    chk({tag, "_tx_start"},  {31'h0, o_tx_start},  32'h0);
    chk({tag, "_capture"},   o_capture,            32'h0);
    chk({tag, "_busy"},      {31'h0, o_busy},      32'h0);
    chk({tag, "_bit_tick"},  {31'h0, o_bit_tick},  32'h0);
    chk({tag, "_done_tick"}, {31'h0, o_done_tick}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur_cap;
    logic [31:0] d;
    logic [31:0] p;
    int          base;
    rst_n          = 1'b0;
    i_serial_in    = 1'b0;
    i_start        = 1'b0;
    i_stop         = 1'b0;
    i_freq_pattern = '0;
    spur_done      = 1'b0;
    cur_cap        = '0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    base = done_cnt;
    run_capture(32'hA5A51234, 32'hFFFFFFFF, -1, 20, cur_cap);
    wait_done(base);
    cur_cap = 32'hA5A51234;

    base = done_cnt;
    run_capture(32'h0F0F00FF, 32'h0000FFFF, -1, 40, cur_cap);
    wait_done(base);
    cur_cap = 32'h0F0F00FF;

    // Abort at bit 10, then a clean run.
    base = done_cnt;
    run_capture($urandom, $urandom, 10, 7, cur_cap);
    repeat (20) @(posedge clk);
    #1 chk("no_done_after_stop", done_cnt, base);
    d = $urandom;
    p = $urandom;
    run_capture(d, p, -1, 9, cur_cap);
    wait_done(base);
    cur_cap = d;

    // Start and stop while waiting on the UART.
    base = done_cnt;
    d = $urandom;
    p = $urandom;
    run_capture(d, p, -1, 12, cur_cap);
    wait_tx_start(2);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    chk("busy_during_wait", {31'h0, o_busy}, 32'h1);
    wait_done(base);
    cur_cap = d;

    // Reset while waiting after byte 1.
    base = done_cnt;
    run_capture($urandom, $urandom, -1, 15, cur_cap);
    wait_tx_start(1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    exp_bytes.delete();
    exp_cap.delete();
    exp_last.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cur_cap = '0;
    repeat (40) @(posedge clk);
    #1 chk("no_done_after_reset", done_cnt, base);
    chk("idle_after_reset", {31'h0, o_busy}, 32'h0);

    for (int r = 0; r < 6; r++) begin
      base = done_cnt;
      d = $urandom;
      p = $urandom;
      run_capture(d, p, -1, $urandom_range(5, 60), cur_cap);
      wait_done(base);
      cur_cap = d;
    end

    chk("byte_queue_drained", exp_bytes.size(), 0);
    chk("capture_queue_drained", exp_cap.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
